bpu_upd_sched: RTL and testbench

Scheduler sharing a single-port predictor table (PHT/BTB bank) between fetch-stage prediction reads and EX-stage update writes. Accepts update packets from the EX update buffer into a small FIFO, interleaves them into idle read slots, and forces drain when the queue fills or an update starves. Sits between the EX update buffer, the fetch predictor lookup, and the table SRAM port.

---
 rtl/bpu_upd_sched_pkg.sv | 20 ++
 rtl/bpu_upd_sched_upd_fifo.sv | 81 ++++++++
 rtl/bpu_upd_sched.sv | 154 +++++++++++++++
 tb/tb_bpu_upd_sched.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bpu_upd_sched_pkg.sv
// Shared predictor-table definitions for the update scheduler.
//   IDX_W_DEF / DATA_W_DEF : default table index / entry widths
//   sched_state_e          : scheduler mode (read priority / forced drain)
//   upd_pkt_t              : update packet {idx, data} at default widths
package bpu_upd_sched_pkg;

  localparam int unsigned IDX_W_DEF  = 10;
  localparam int unsigned DATA_W_DEF = 64;

  typedef enum logic {
    RD_PRI = 1'b0,
    DRAIN  = 1'b1
  } sched_state_e;

  typedef struct packed {
    logic [IDX_W_DEF-1:0]  idx;
    logic [DATA_W_DEF-1:0] data;
  } upd_pkt_t;

endpackage

// File: rtl/bpu_upd_sched_upd_fifo.sv
// Circular update FIFO for the predictor-table scheduler.
//   clk, rst              : clock, async active-high reset
//   push/push_idx/data    : write an update at the tail (caller guarantees not full)
//   pop                   : drop the head entry (caller guarantees not empty)
//   head_idx/head_data    : current head entry
//   cnt                   : occupancy 0..DEPTH
//   match_idx/match_age/age_data (UPD_FWD_EN only): per-entry index match,
//     ordered by age (bit 0 = head/oldest), plus the data of each age slot.
// Optional feature macro: UPD_FWD_EN.
module bpu_upd_sched_upd_fifo
  import bpu_upd_sched_pkg::*;
#(
  parameter int unsigned IDX_W  = IDX_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned DEPTH  = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      push,
  input  logic [IDX_W-1:0]          push_idx,
  input  logic [DATA_W-1:0]         push_data,
  input  logic                      pop,
  output logic [IDX_W-1:0]          head_idx,
  output logic [DATA_W-1:0]         head_data,
  output logic [$clog2(DEPTH):0]    cnt
`ifdef UPD_FWD_EN
  ,
  input  logic [IDX_W-1:0]          match_idx,
  output logic [DEPTH-1:0]          match_age,
  output logic [DEPTH-1:0][DATA_W-1:0] age_data
`endif
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [IDX_W-1:0]  idx_mem  [DEPTH];
  logic [DATA_W-1:0] data_mem [DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: ;
      endcase
    end
  end

  // Storage needs no reset: cnt masks stale slots.
  always_ff @(posedge clk) begin
    if (push) begin
      idx_mem[wr_ptr]  <= push_idx;
      data_mem[wr_ptr] <= push_data;
    end
  end

  assign head_idx  = idx_mem[rd_ptr];
  assign head_data = data_mem[rd_ptr];

`ifdef UPD_FWD_EN
  // Walk slots in age order so the consumer can pick the youngest match.
  always_comb begin
    match_age = '0;
    age_data  = '0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      match_age[k] = (CW'(k) < cnt) && (idx_mem[rd_ptr + PW'(k)] == match_idx);
      age_data[k]  = data_mem[rd_ptr + PW'(k)];
    end
  end
`endif

endmodule

// File: rtl/bpu_upd_sched.sv
// Scheduler sharing a single-port predictor table between fetch lookups
// (reads) and EX-stage updates (writes). Updates are queued in a FIFO and
// written in idle read slots; a drain mode takes over the port when the
// queue reaches HI_WM or the head update has waited STARVE_LIMIT cycles.
//   upd_valid/idx/data, upd_ready : update push handshake
//   rd_valid/rd_idx, rd_ready     : lookup request / combinational grant
//   tbl_en/we/idx/wdata           : registered table port strobes
//   q_cnt                         : FIFO occupancy
//   fwd_hit/fwd_data              : youngest queued update matching rd_idx
// Optional feature macro: UPD_FWD_EN (store-to-lookup forwarding). When
// undefined, fwd_hit/fwd_data are tied to zero and no comparators exist.
module bpu_upd_sched
  import bpu_upd_sched_pkg::*;
#(
  parameter int unsigned IDX_W        = IDX_W_DEF,
  parameter int unsigned DATA_W       = DATA_W_DEF,
  parameter int unsigned DEPTH        = 4,
  parameter int unsigned HI_WM        = 3,
  parameter int unsigned LO_WM        = 1,
  parameter int unsigned STARVE_LIMIT = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   upd_valid,
  input  logic [IDX_W-1:0]       upd_idx,
  input  logic [DATA_W-1:0]      upd_data,
  output logic                   upd_ready,
  input  logic                   rd_valid,
  input  logic [IDX_W-1:0]       rd_idx,
  output logic                   rd_ready,
  output logic                   tbl_en,
  output logic                   tbl_we,
  output logic [IDX_W-1:0]       tbl_idx,
  output logic [DATA_W-1:0]      tbl_wdata,
  output logic [$clog2(DEPTH):0] q_cnt,
  output logic                   fwd_hit,
  output logic [DATA_W-1:0]      fwd_data
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);

  sched_state_e      state;
  logic [SW-1:0]     starve_cnt;
  logic              push;
  logic              do_rd;
  logic              do_pop;
  logic [CW-1:0]     q_next;
  logic [IDX_W-1:0]  head_idx;
  logic [DATA_W-1:0] head_data;

`ifdef UPD_FWD_EN
  logic [DEPTH-1:0]             match_age;
  logic [DEPTH-1:0][DATA_W-1:0] age_data;
`endif

  bpu_upd_sched_upd_fifo #(
    .IDX_W  (IDX_W),
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_idx  (upd_idx),
    .push_data (upd_data),
    .pop       (do_pop),
    .head_idx  (head_idx),
    .head_data (head_data),
    .cnt       (q_cnt)
`ifdef UPD_FWD_EN
    ,
    .match_idx (rd_idx),
    .match_age (match_age),
    .age_data  (age_data)
`endif
  );

  // Full is judged on the registered count; a same-cycle pop does not free a slot.
  assign upd_ready = (q_cnt < CW'(DEPTH));
  assign push      = upd_valid & upd_ready;

  always_comb begin
    rd_ready = 1'b0;
    do_rd    = 1'b0;
    do_pop   = 1'b0;
    case (state)
      RD_PRI: begin
        if (rd_valid) begin
          rd_ready = 1'b1;
          do_rd    = 1'b1;
        end else if (q_cnt != '0) begin
          do_pop = 1'b1;
        end
      end
      DRAIN: begin
        if (q_cnt != '0) do_pop = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    q_next = q_cnt;
    if (push && !do_pop)      q_next = q_cnt + 1'b1;
    else if (!push && do_pop) q_next = q_cnt - 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= RD_PRI;
      starve_cnt <= '0;
      tbl_en     <= 1'b0;
      tbl_we     <= 1'b0;
      tbl_idx    <= '0;
      tbl_wdata  <= '0;
    end else begin
      tbl_en <= do_rd | do_pop;
      tbl_we <= do_pop;
      if (do_pop) begin
        tbl_idx   <= head_idx;
        tbl_wdata <= head_data;
      end else if (do_rd) begin
        tbl_idx <= rd_idx;
      end

      if (do_pop || q_cnt == '0)
        starve_cnt <= '0;
      else if (state == RD_PRI && starve_cnt != SW'(STARVE_LIMIT))
        starve_cnt <= starve_cnt + 1'b1;

      case (state)
        RD_PRI: if (q_cnt >= CW'(HI_WM) || starve_cnt == SW'(STARVE_LIMIT)) state <= DRAIN;
        DRAIN:  if (q_next <= CW'(LO_WM)) state <= RD_PRI;
        default: state <= RD_PRI;
      endcase
    end
  end

`ifdef UPD_FWD_EN
  // Later age slots overwrite earlier ones, so the youngest match wins.
  always_comb begin
    fwd_hit  = rd_valid & (|match_age);
    fwd_data = '0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      if (rd_valid && match_age[k]) fwd_data = age_data[k];
    end
  end
`else
  assign fwd_hit  = 1'b0;
  assign fwd_data = '0;
`endif

endmodule

// File: tb/tb_bpu_upd_sched.sv
module tb_bpu_upd_sched;
  import bpu_upd_sched_pkg::*;

  localparam int IDX_W  = 10;
  localparam int DATA_W = 64;
  localparam int DEPTH  = 4;
  localparam int HI_WM  = 3;
  localparam int LO_WM  = 1;
  localparam int SLIM   = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic              upd_valid;
  logic [IDX_W-1:0]  upd_idx;
  logic [DATA_W-1:0] upd_data;
  logic              upd_ready;
  logic              rd_valid;
  logic [IDX_W-1:0]  rd_idx;
  logic              rd_ready;
  logic              tbl_en;
  logic              tbl_we;
  logic [IDX_W-1:0]  tbl_idx;
  logic [DATA_W-1:0] tbl_wdata;
  logic [2:0]        q_cnt;
  logic              fwd_hit;
  logic [DATA_W-1:0] fwd_data;

  always #5 clk = ~clk;

  bpu_upd_sched #(
    .IDX_W(IDX_W), .DATA_W(DATA_W), .DEPTH(DEPTH),
    .HI_WM(HI_WM), .LO_WM(LO_WM), .STARVE_LIMIT(SLIM)
  ) dut (
    .clk(clk), .rst(rst),
    .upd_valid(upd_valid), .upd_idx(upd_idx), .upd_data(upd_data), .upd_ready(upd_ready),
    .rd_valid(rd_valid), .rd_idx(rd_idx), .rd_ready(rd_ready),
    .tbl_en(tbl_en), .tbl_we(tbl_we), .tbl_idx(tbl_idx), .tbl_wdata(tbl_wdata),
    .q_cnt(q_cnt), .fwd_hit(fwd_hit), .fwd_data(fwd_data)
  );

  int errors = 0;
  int checks = 0;

  // Reference model: the pending updates as a queue, plus mode and wait age.
  upd_pkt_t mq[$];
  bit       m_drain;
  int       m_starve;
  upd_pkt_t pushed_log[$];
  upd_pkt_t writes_log[$];

  // Values observed in the latest cycle (pre-edge comb, post-edge registered).
  logic              a_rd_ready, a_upd_ready, a_fh;
  logic [DATA_W-1:0] a_fd;
  int                a_qpre, a_q;
  logic              a_en, a_we;
  logic [IDX_W-1:0]  a_idx;
  logic [DATA_W-1:0] a_wd;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_drain  = 0;
    m_starve = 0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_tbl_en"},    tbl_en, 0);
    chk({tag, "_tbl_we"},    tbl_we, 0);
    chk({tag, "_tbl_idx"},   tbl_idx, 0);
    chk({tag, "_tbl_wdata"}, tbl_wdata, 0);
    chk({tag, "_q_cnt"},     q_cnt, 0);
    chk({tag, "_fwd_hit"},   fwd_hit, 0);
    chk({tag, "_upd_ready"}, upd_ready, 1);
  endtask

  // One clock cycle: called at a falling edge, returns at the next falling edge.
  task automatic cycle(input logic rv, input logic [IDX_W-1:0] ridx,
                       input logic uv, input logic [IDX_W-1:0] uidx,
                       input logic [DATA_W-1:0] udata);
    bit                g_rd, g_wr, m_push, m_fh, pre_drain;
    logic [DATA_W-1:0] m_fd;
    int                pre_size, pre_starve;
    bit                e_en, e_we;
    logic [IDX_W-1:0]  e_idx;
    logic [DATA_W-1:0] e_wd;
    upd_pkt_t          p;
    rd_valid  = rv;
    rd_idx    = ridx;
    upd_valid = uv;
    upd_idx   = uidx;
    upd_data  = udata;
    #1;
    pre_size   = mq.size();
    pre_starve = m_starve;
    pre_drain  = m_drain;
    g_rd   = !m_drain && rv;
    g_wr   = !g_rd && (pre_size > 0);
    m_push = uv && (pre_size < DEPTH);
    m_fh = 0;
    m_fd = '0;
    for (int i = 0; i < pre_size; i++)
      if (rv && mq[i].idx == ridx) begin
        m_fh = 1;
        m_fd = mq[i].data;
      end
`ifndef UPD_FWD_EN
    m_fh = 0;
    m_fd = '0;
`endif
    a_rd_ready  = rd_ready;
    a_upd_ready = upd_ready;
    a_qpre      = int'(q_cnt);
    a_fh        = fwd_hit;
    a_fd        = fwd_data;
    chk("rd_ready",  rd_ready, g_rd);
    chk("upd_ready", upd_ready, pre_size < DEPTH);
    chk("q_cnt_pre", q_cnt, pre_size);
    chk("fwd_hit",   fwd_hit, m_fh);
    chk("fwd_data",  fwd_data, m_fd);

    e_en = g_rd || g_wr;
    e_we = g_wr;
    e_idx = '0;
    e_wd  = '0;
    if (g_wr) begin
      p = mq.pop_front();
      e_idx = p.idx;
      e_wd  = p.data;
    end else if (g_rd) begin
      e_idx = ridx;
    end
    if (m_push) begin
      p.idx  = uidx;
      p.data = udata;
      mq.push_back(p);
      pushed_log.push_back(p);
    end
    if (g_wr || pre_size == 0) m_starve = 0;
    else if (!pre_drain && m_starve < SLIM) m_starve++;
    if (!pre_drain) begin
      if (pre_size >= HI_WM || pre_starve == SLIM) m_drain = 1;
    end else if (mq.size() <= LO_WM) begin
      m_drain = 0;
    end

    @(posedge clk);
    #1;
    a_q   = int'(q_cnt);
    a_en  = tbl_en;
    a_we  = tbl_we;
    a_idx = tbl_idx;
    a_wd  = tbl_wdata;
    chk("tbl_en", tbl_en, e_en);
    chk("tbl_we", tbl_we, e_we);
    if (e_en) chk("tbl_idx", tbl_idx, e_idx);
    if (e_we) chk("tbl_wdata", tbl_wdata, e_wd);
    chk("q_cnt", q_cnt, mq.size());
    if (tbl_en && tbl_we) begin
      p.idx  = tbl_idx;
      p.data = tbl_wdata;
      writes_log.push_back(p);
    end
    @(negedge clk);
  endtask

  typedef struct {
    logic              rv;
    logic [IDX_W-1:0]  ridx;
    logic              uv;
    logic [IDX_W-1:0]  uidx;
    logic [DATA_W-1:0] udata;
    logic              e_rdy;
    logic              e_urdy;
    int                e_q;
    logic              e_en;
    logic              e_we;
    logic [IDX_W-1:0]  e_idx;
    logic [DATA_W-1:0] e_wd;
  } vec_t;

  vec_t tv[11];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    int wr_at, wr_rdy, stall_k, stall_q, t;
    bit accepted;
    logic [IDX_W-1:0] ri;

    // rv ridx uv uidx udata | rd_ready upd_ready q en we idx wdata
    tv[0]  = '{0, 10'h00, 1, 10'h05, 64'hA5,  0, 1, 1, 0, 0, 10'h00, 64'h0};
    tv[1]  = '{0, 10'h00, 0, 10'h00, 64'h0,   0, 1, 0, 1, 1, 10'h05, 64'hA5};
    tv[2]  = '{0, 10'h00, 0, 10'h00, 64'h0,   0, 1, 0, 0, 0, 10'h00, 64'h0};
    tv[3]  = '{1, 10'h20, 1, 10'h11, 64'h111, 1, 1, 1, 1, 0, 10'h20, 64'h0};
    tv[4]  = '{1, 10'h21, 1, 10'h12, 64'h222, 1, 1, 2, 1, 0, 10'h21, 64'h0};
    tv[5]  = '{1, 10'h22, 1, 10'h13, 64'h333, 1, 1, 3, 1, 0, 10'h22, 64'h0};
    tv[6]  = '{1, 10'h23, 0, 10'h00, 64'h0,   1, 1, 3, 1, 0, 10'h23, 64'h0};
    tv[7]  = '{1, 10'h25, 0, 10'h00, 64'h0,   0, 1, 2, 1, 1, 10'h11, 64'h111};
    tv[8]  = '{1, 10'h26, 0, 10'h00, 64'h0,   0, 1, 1, 1, 1, 10'h12, 64'h222};
    tv[9]  = '{1, 10'h24, 0, 10'h00, 64'h0,   1, 1, 1, 1, 0, 10'h24, 64'h0};
    tv[10] = '{0, 10'h00, 0, 10'h00, 64'h0,   0, 1, 0, 1, 1, 10'h13, 64'h333};

    rst = 1'b0;
    upd_valid = 0; upd_idx = '0; upd_data = '0;
    rd_valid = 0; rd_idx = '0;
    model_reset();
    #1 rst = 1'b1;
    #11;
    check_reset_outputs("reset");
    @(negedge clk);
    rst = 1'b0;

    // Directed vectors: single update, then 3 queued updates under read pressure.
    for (int i = 0; i < 11; i++) begin
      cycle(tv[i].rv, tv[i].ridx, tv[i].uv, tv[i].uidx, tv[i].udata);
      chk($sformatf("vec%0d_rd_ready", i), a_rd_ready, tv[i].e_rdy);
      chk($sformatf("vec%0d_upd_ready", i), a_upd_ready, tv[i].e_urdy);
      chk($sformatf("vec%0d_q_cnt", i), a_q, tv[i].e_q);
      chk($sformatf("vec%0d_tbl_en", i), a_en, tv[i].e_en);
      chk($sformatf("vec%0d_tbl_we", i), a_we, tv[i].e_we);
      if (tv[i].e_en) chk($sformatf("vec%0d_tbl_idx", i), a_idx, tv[i].e_idx);
      if (tv[i].e_we) chk($sformatf("vec%0d_tbl_wdata", i), a_wd, tv[i].e_wd);
    end

    // Reads only.
    for (int i = 0; i < 20; i++) begin
      ri = IDX_W'($urandom);
      cycle(1, ri, 0, '0, '0);
      chk("rdonly_ready", a_rd_ready, 1);
      chk("rdonly_en", a_en, 1);
      chk("rdonly_we", a_we, 0);
      chk("rdonly_idx", a_idx, ri);
    end

    // Starvation: one update behind continuous reads.
    cycle(1, 10'h30, 1, 10'h07, 64'h77);
    wr_at = -1;
    wr_rdy = -1;
    for (int n = 1; n <= 40 && wr_at < 0; n++) begin
      cycle(1, IDX_W'(10'h30 + n), 0, '0, '0);
      if (a_we) begin
        wr_at  = n;
        wr_rdy = a_rd_ready;
      end
    end
    chk("starve_write_cycle", wr_at, 10);
    chk("starve_drain_stall", wr_rdy, 0);
    chk("starve_write_data", a_wd, 64'h77);
    cycle(1, 10'h3F, 0, '0, '0);
    chk("starve_reads_resume", a_rd_ready, 1);

    // Overfill: 5 pushes into a 4-deep queue, then check write order.
    pushed_log.delete();
    writes_log.delete();
    stall_k = -1;
    stall_q = -1;
    for (int k = 0; k < 5; k++) begin
      accepted = 0;
      for (t = 0; t < 10 && !accepted; t++) begin
        cycle(1, 10'h50, 1, IDX_W'(10'h40 + k), 64'hF0 + 64'(k));
        if (a_upd_ready) accepted = 1;
        else if (stall_k < 0) begin
          stall_k = k;
          stall_q = a_qpre;
        end
      end
      chk("full_push_accepted", accepted, 1);
    end
    chk("full_stall_on_5th", stall_k, 4);
    chk("full_stall_q_cnt", stall_q, DEPTH);
    for (t = 0; t < 60 && mq.size() > 0; t++) cycle(1, 10'h51, 0, '0, '0);
    chk("full_drained", q_cnt, 0);
    chk("order_len", writes_log.size(), pushed_log.size());
    for (int i = 0; i < pushed_log.size() && i < writes_log.size(); i++) begin
      chk($sformatf("order%0d_idx", i), writes_log[i].idx, pushed_log[i].idx);
      chk($sformatf("order%0d_data", i), writes_log[i].data, pushed_log[i].data);
    end

    // Refill into drain mode, then reset between clock edges.
    for (int k = 0; k < 4; k++) cycle(1, 10'h60, 1, IDX_W'(10'h70 + k), 64'hC0 + 64'(k));
    cycle(1, 10'h60, 0, '0, '0);
    chk("middrain_stall", a_rd_ready, 0);
    chk("middrain_q", a_q, 3);
    rd_valid = 1;
    #2 rst = 1'b1;
    #1;
    check_reset_outputs("async_reset");
    chk("async_reset_rd_ready", rd_ready, 1);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    cycle(0, '0, 0, '0, '0);
    chk("post_reset_idle", a_en, 0);

    // Forwarding from the queue to a lookup.
    cycle(1, 10'h3FF, 1, 10'h10, 64'h1);
    cycle(1, 10'h3FF, 1, 10'h10, 64'h2);
    cycle(1, 10'h10, 0, '0, '0);
`ifdef UPD_FWD_EN
    chk("fwd_youngest_hit", a_fh, 1);
    chk("fwd_youngest_data", a_fd, 64'h2);
`else
    chk("fwd_off_hit", a_fh, 0);
    chk("fwd_off_data", a_fd, 0);
`endif
    cycle(1, 10'h11, 0, '0, '0);
    chk("fwd_miss", a_fh, 0);
    for (int i = 0; i < 3; i++) cycle(0, '0, 0, '0, '0);

    // Random traffic against the model, with varying read pressure.
    for (int i = 0; i < 3000; i++) begin
      int pct;
      pct = ((i / 250) % 3 == 0) ? 90 : (((i / 250) % 3 == 1) ? 50 : 10);
      cycle(($urandom % 100) < pct, IDX_W'($urandom_range(0, 7)),
            ($urandom % 100) < 50, IDX_W'($urandom_range(0, 7)),
            {$urandom, $urandom});
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
